// File: rtl/text_buffer_ctrl_pkg.sv
// Shared constants, character codes and FSM encoding for the OLED text buffer.
package text_buffer_ctrl_pkg;

  localparam int TEXT_COLS = 16;
  localparam int TEXT_ROWS = 8;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  typedef enum logic [1:0] {
    ST_CLEAR_ALL  = 2'd0,
    ST_IDLE       = 2'd1,
    ST_WRITE      = 2'd2,
    ST_CLEAR_LINE = 2'd3
  } state_e;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

  // Logical row is rotated by the scroll offset; 3-bit add wraps mod 8.
  function automatic logic [6:0] phys_addr(input logic [2:0] row, input logic [2:0] top,
                                           input logic [3:0] col);
    logic [2:0] prow;
    prow = row + top;
    return {prow, col};
  endfunction

endpackage

// File: rtl/text_buffer_ctrl_ram.sv
// 128x8 single-port synchronous character RAM with registered read data.
module text_ram (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] addr,
  input  logic       we,
  input  logic [7:0] wdata,
  input  logic       re,
  output logic [7:0] rdata
);

  logic [7:0] mem [128];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata_q <= 8'h00;
    else if (re) rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/text_buffer_ctrl.sv
// Character buffer controller: display reads win the RAM, stream writes stall behind them.
// Optional cursor blink overlay on read data is enabled by TEXT_CURSOR_BLINK_EN.
module text_buffer_ctrl
  import text_buffer_ctrl_pkg::*;
#(
  parameter logic [7:0] FILL_CHAR   = 8'h20,
  parameter logic [7:0] CURSOR_CHAR = 8'h7F,
  parameter int         BLINK_BITS  = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_char,
  output logic       in_ready,
  input  logic       rd_en,
  input  logic [2:0] rd_row,
  input  logic [3:0] rd_col,
  output logic [7:0] rd_data,
  output logic       rd_ack,
  output logic [2:0] cursor_row,
  output logic [3:0] cursor_col,
  output logic       busy
);

  state_e     state_q, state_d;
  logic [2:0] row_q, row_d, top_q, top_d;
  logic [3:0] col_q, col_d;
  logic [6:0] clr_q, clr_d;
  logic [7:0] char_q, char_d;
  logic       rd_ack_q;
  logic       do_nl;

  logic       wr_req, ram_we;
  logic [6:0] wr_addr, ram_addr, rd_addr;
  logic [7:0] wr_data, ram_rdata;
  logic [2:0] line_row;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_CLEAR_ALL;
      row_q    <= 3'd0;
      col_q    <= 4'd0;
      top_q    <= 3'd0;
      clr_q    <= 7'd0;
      char_q   <= 8'h00;
      rd_ack_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      top_q    <= top_d;
      clr_q    <= clr_d;
      char_q   <= char_d;
      rd_ack_q <= rd_en;
    end
  end

  // Every RAM-writing step holds while rd_en owns the port.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    top_d   = top_q;
    clr_d   = clr_q;
    char_d  = char_q;
    do_nl   = 1'b0;
    case (state_q)
      ST_CLEAR_ALL: begin
        if (!rd_en) begin
          if (clr_q == 7'd127) begin
            row_d   = 3'd0;
            col_d   = 4'd0;
            top_d   = 3'd0;
            state_d = ST_IDLE;
          end else begin
            clr_d = clr_q + 7'd1;
          end
        end
      end
      ST_IDLE: begin
        if (in_valid) begin
          char_d  = in_char;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
        if (is_printable(char_q)) begin
          if (rd_en)                state_d = ST_WRITE;
          else if (col_q != 4'hF)   col_d = col_q + 4'd1;
          else                      do_nl = 1'b1;
        end else begin
          case (char_q)
            CH_LF: do_nl = 1'b1;
            CH_CR: col_d = 4'd0;
            CH_BS: if (col_q != 4'd0) col_d = col_q - 4'd1;
            CH_FF: begin
              clr_d   = 7'd0;
              state_d = ST_CLEAR_ALL;
            end
            default: ;
          endcase
        end
        if (do_nl) begin
          col_d = 4'd0;
          if (row_q != 3'd7) begin
            row_d = row_q + 3'd1;
          end else begin
            top_d   = top_q + 3'd1;
            clr_d   = 7'd0;
            state_d = ST_CLEAR_LINE;
          end
        end
      end
      ST_CLEAR_LINE: begin
        if (!rd_en) begin
          if (clr_q[3:0] == 4'hF) state_d = ST_IDLE;
          else                    clr_d = clr_q + 7'd1;
        end
      end
      default: state_d = ST_CLEAR_ALL;
    endcase
  end

  assign line_row = 3'd7 + top_q;

  always_comb begin
    in_ready = (state_q == ST_IDLE);
    busy     = (state_q == ST_CLEAR_ALL) || (state_q == ST_CLEAR_LINE);
    wr_req   = 1'b0;
    wr_addr  = clr_q;
    wr_data  = FILL_CHAR;
    case (state_q)
      ST_CLEAR_ALL:  wr_req = 1'b1;
      ST_WRITE: begin
        wr_req  = is_printable(char_q);
        wr_addr = phys_addr(row_q, top_q, col_q);
        wr_data = char_q;
      end
      ST_CLEAR_LINE: begin
        wr_req  = 1'b1;
        wr_addr = {line_row, clr_q[3:0]};
      end
      default: ;
    endcase
  end

  assign rd_addr  = phys_addr(rd_row, top_q, rd_col);
  assign ram_we   = wr_req && !rd_en;
  assign ram_addr = rd_en ? rd_addr : wr_addr;

  text_ram u_ram (
    .clk   (clk),
    .rst   (rst),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (wr_data),
    .re    (rd_en),
    .rdata (ram_rdata)
  );

  assign rd_ack     = rd_ack_q;
  assign cursor_row = row_q;
  assign cursor_col = col_q;

`ifdef TEXT_CURSOR_BLINK_EN
  logic [BLINK_BITS-1:0] blink_q;
  logic [6:0]            rd_addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_q   <= '0;
      rd_addr_q <= 7'd0;
    end else begin
      blink_q <= blink_q + 1'b1;
      if (rd_en) rd_addr_q <= rd_addr;
    end
  end

  assign rd_data = (blink_q[BLINK_BITS-1] && (rd_addr_q == phys_addr(row_q, top_q, col_q)))
                   ? CURSOR_CHAR : ram_rdata;
`else
  logic unused_blink_cfg;
  assign unused_blink_cfg = ^{CURSOR_CHAR, BLINK_BITS[0]};
  assign rd_data = ram_rdata;
`endif

endmodule

// File: tb/tb_text_buffer_ctrl.sv
// Self-checking bench for text_buffer_ctrl against a logical-screen model.
module tb_text_buffer_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_char = 8'h00;
  logic       in_ready;
  logic       rd_en = 1'b0;
  logic [2:0] rd_row = 3'd0;
  logic [3:0] rd_col = 4'd0;
  logic [7:0] rd_data;
  logic       rd_ack;
  logic [2:0] cursor_row;
  logic [3:0] cursor_col;
  logic       busy;

  int total = 0;
  int bad   = 0;

  // Model: screen as seen by the viewer, scrolling shifts rows up.
  logic [7:0] scr [8][16];
  int mrow = 0;
  int mcol = 0;

  text_buffer_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_char(in_char), .in_ready(in_ready),
    .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data), .rd_ack(rd_ack),
    .cursor_row(cursor_row), .cursor_col(cursor_col), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 16; c++) scr[r][c] = 8'h20;
    mrow = 0;
    mcol = 0;
  endtask

  task automatic model_newline();
    mcol = 0;
    if (mrow < 7) mrow++;
    else begin
      for (int r = 0; r < 7; r++)
        for (int c = 0; c < 16; c++) scr[r][c] = scr[r+1][c];
      for (int c = 0; c < 16; c++) scr[7][c] = 8'h20;
    end
  endtask

  task automatic model_apply(input logic [7:0] ch);
    if (ch >= 8'h20 && ch <= 8'h7E) begin
      scr[mrow][mcol] = ch;
      if (mcol < 15) mcol++;
      else model_newline();
    end else if (ch == 8'h0A) model_newline();
    else if (ch == 8'h0D) mcol = 0;
    else if (ch == 8'h08) begin
      if (mcol > 0) mcol--;
    end else if (ch == 8'h0C) model_clear();
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    check({"ready_", tag}, 32'(in_ready), 32'd1);
  endtask

  task automatic send(input logic [7:0] ch);
    wait_ready("send");
    in_valid = 1'b1;
    in_char  = ch;
    tick();
    in_valid = 1'b0;
    model_apply(ch);
  endtask

  task automatic read_chk(input string tag, input int r, input int c);
    rd_en  = 1'b1;
    rd_row = 3'(r);
    rd_col = 4'(c);
    tick();
    rd_en = 1'b0;
    check({tag, "_ack"}, 32'(rd_ack), 32'd1);
    check({tag, "_data"}, 32'(rd_data), 32'(scr[r][c]));
  endtask

  task automatic check_cursor(input string tag);
    check({tag, "_crow"}, 32'(cursor_row), 32'(mrow));
    check({tag, "_ccol"}, 32'(cursor_col), 32'(mcol));
  endtask

  // Called right after the accepting edge; counts cycles with busy high.
  task automatic count_busy(output int n);
    tick();
    n = 0;
    while (busy === 1'b1 && n < 500) begin
      n++;
      tick();
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_rd_ack"}, 32'(rd_ack), 32'd0);
    check({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_crow"}, 32'(cursor_row), 32'd0);
    check({tag, "_ccol"}, 32'(cursor_col), 32'd0);
  endtask

  task automatic release_and_clear(input string tag);
    logic ok;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 128; i++) begin
      if (busy !== 1'b1 || in_ready !== 1'b0) ok = 1'b0;
      tick();
    end
    check({tag, "_busy128"}, 32'(ok), 32'd1);
    check({tag, "_ready_after"}, 32'(in_ready), 32'd1);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    model_clear();
  endtask

  initial begin
    int n;
    logic ok;
    logic [7:0] ch;

    // Reset and power-up clear
    #12;
    check_reset_vals("reset");
    release_and_clear("init");
    check_cursor("init");
    read_chk("init_rd00", 0, 0);
    tick();
    check("no_ack_idle", 32'(rd_ack), 32'd0);

    // "Hi"
    send(8'h48);
    send(8'h69);
    wait_ready("hi");
    check_cursor("hi");
    read_chk("hi_00", 0, 0);
    read_chk("hi_01", 0, 1);
    read_chk("hi_02", 0, 2);

    // Column wrap
    send(8'h0D);
    for (int i = 0; i < 16; i++) send(8'h41);
    wait_ready("wrap");
    check_cursor("wrap");
    check("wrap_model_row", 32'(mrow), 32'd1);
    read_chk("wrap_015", 0, 15);
    read_chk("wrap_10", 1, 0);

    // Scroll
    send(8'h0C);
    for (int r = 0; r < 8; r++) begin
      send(8'h41 + 8'(r));
      if (r < 7) send(8'h0A);
    end
    send(8'h20);
    send(8'h20);
    wait_ready("pre_scroll");
    check_cursor("pre_scroll");
    send(8'h0A);
    count_busy(n);
    check("scroll_busy16", 32'(n), 32'd16);
    wait_ready("scroll");
    check_cursor("scroll");
    read_chk("scroll_00", 0, 0);
    check("scroll_00_lit", 32'(rd_data), 32'h42);
    read_chk("scroll_60", 6, 0);
    check("scroll_60_lit", 32'(rd_data), 32'h48);
    for (int c = 0; c < 16; c++) read_chk("scroll_7c", 7, c);

    // Held read starves a pending write
    send(8'h0C);
    count_busy(n);
    check("ff1_busy128", 32'(n), 32'd128);
    wait_ready("hold");
    in_valid = 1'b1;
    in_char  = 8'h5A;
    tick();
    in_valid = 1'b0;
    rd_en = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rd_row = 3'd0;
      rd_col = 4'(i);
      tick();
      if (rd_ack !== 1'b1 || in_ready !== 1'b0 || rd_data !== scr[0][i]) ok = 1'b0;
    end
    rd_en = 1'b0;
    check("hold_ack_ready_data", 32'(ok), 32'd1);
    check_cursor("hold_stalled");
    model_apply(8'h5A);
    wait_ready("hold_done");
    check_cursor("hold_done");
    read_chk("hold_rd00", 0, 0);

    // Form feed after content
    send(8'h31);
    send(8'h0A);
    send(8'h32);
    send(8'h0C);
    count_busy(n);
    check("ff2_busy128", 32'(n), 32'd128);
    wait_ready("ff2");
    check_cursor("ff2");
    ok = 1'b1;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 16; c++) begin
        rd_en  = 1'b1;
        rd_row = 3'(r);
        rd_col = 4'(c);
        tick();
        if (rd_ack !== 1'b1 || rd_data !== 8'h20) ok = 1'b0;
      end
    rd_en = 1'b0;
    check("ff2_all_space", 32'(ok), 32'd1);

    // Randomized stream with read interference
    for (int it = 0; it < 150; it++) begin
      int sel;
      sel = int'($urandom_range(0, 99));
      if (sel < 68)      ch = 8'($urandom_range(8'h20, 8'h7E));
      else if (sel < 80) ch = 8'h0A;
      else if (sel < 87) ch = 8'h0D;
      else if (sel < 95) ch = 8'h08;
      else if (sel < 98) ch = 8'h01;
      else               ch = 8'h0C;
      send(ch);
      if ($urandom_range(0, 2) == 0) begin
        int k;
        k = int'($urandom_range(1, 3));
        rd_en = 1'b1;
        for (int j = 0; j < k; j++) begin
          rd_row = 3'($urandom_range(0, 7));
          rd_col = 4'($urandom_range(0, 15));
          tick();
          check("rand_int_ack", 32'(rd_ack), 32'd1);
        end
        rd_en = 1'b0;
      end
      wait_ready("rand");
      check_cursor("rand");
      read_chk("rand_rd", int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
      read_chk("rand_rd_cur", mrow, int'($urandom_range(0, 15)));
      tick();
      check("rand_no_ack", 32'(rd_ack), 32'd0);
    end

    // Reset in the middle of a line clear
    send(8'h0C);
    for (int i = 0; i < 7; i++) send(8'h0A);
    wait_ready("pre_rst");
    check_cursor("pre_rst");
    send(8'h0A);
    tick();
    tick();
    tick();
    check("mid_clear_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_vals("async_rst");
    release_and_clear("rst_restart");
    check_cursor("rst_restart");
    read_chk("rst_rd00", 0, 0);
    read_chk("rst_rd7f", 7, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
